// File: rtl/commit_scoreboard.sv
// commit_scoreboard: in-order retirement checker. Expected commit records are
// queued by a reference model and compared against the commits the DUT
// actually retires. The first mismatch, unexpected commit or timeout is
// latched, and matched commits are counted.
module commit_scoreboard #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RIDX_W  = 4,
    parameter int unsigned PC_W    = 16,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [PC_W-1:0]          exp_pc,
    input  logic                     exp_we,
    input  logic [RIDX_W-1:0]        exp_rd,
    input  logic [DATA_W-1:0]        exp_data,
    input  logic                     dut_valid,
    input  logic [PC_W-1:0]          dut_pc,
    input  logic                     dut_we,
    input  logic [RIDX_W-1:0]        dut_rd,
    input  logic [DATA_W-1:0]        dut_data,
    output logic                     error,
    output logic [2:0]               err_code,
    output logic [PC_W-1:0]          err_pc,
    output logic [CNT_W-1:0]         commit_cnt,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned AGE_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_PC      = 3'd1;
    localparam logic [2:0] CODE_WE      = 3'd2;
    localparam logic [2:0] CODE_RD      = 3'd3;
    localparam logic [2:0] CODE_DATA    = 3'd4;
    localparam logic [2:0] CODE_UNEXP   = 3'd5;
    localparam logic [2:0] CODE_TIMEOUT = 3'd6;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              we;
        logic [RIDX_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } rec_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_FAIL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    rec_t              mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [AGE_W-1:0]  age;

    rec_t              in_rec;
    rec_t              dut_rec;
    rec_t              head;
    rec_t              cmp_ref;
    logic              is_fail;
    logic              full;
    logic              empty;
    logic              flush_act;
    logic              push;
    logic              consume;
    logic              pop;
    logic              bypass;
    logic              unexpected;
    logic              store;
    logic              age_tick;
    logic              timeout;
    logic              checked;
    logic [2:0]        cmp_code;
    logic              match;
    logic              fail_evt;
    logic [2:0]        fail_code;
    logic [PC_W-1:0]   fail_pc;
    logic [OCC_W-1:0]  occ_next;

    // Field-by-field compare; lowest failing code wins, R0 data never checked.
    function automatic logic [2:0] compare_rec(input rec_t e, input rec_t d);
        logic [2:0] code;
        code = CODE_NONE;
        if (e.pc != d.pc) begin
            code = CODE_PC;
        end else if (e.we != d.we) begin
            code = CODE_WE;
        end else if (e.we && (e.rd != d.rd)) begin
            code = CODE_RD;
        end else if (e.we && (e.rd != '0) && (e.data != d.data)) begin
            code = CODE_DATA;
        end
        return code;
    endfunction

    // Next-state and queue/compare control.
    always_comb begin
        state_nxt  = state;
        in_rec     = {exp_pc, exp_we, exp_rd, exp_data};
        dut_rec    = {dut_pc, dut_we, dut_rd, dut_data};
        head       = mem[rd_ptr];
        is_fail    = (state == S_FAIL);
        full       = (occupancy == OCC_W'(DEPTH));
        empty      = (occupancy == '0);
        exp_ready  = !full && !is_fail;
        flush_act  = flush && !is_fail;
        push       = exp_valid && exp_ready && !flush_act;
        consume    = dut_valid && enable && !is_fail && !flush_act;
        pop        = consume && !empty;
        bypass     = consume && empty && push;
        unexpected = consume && empty && !push;
        store      = push && !bypass;
        cmp_ref    = empty ? in_rec : head;
        cmp_code   = compare_rec(cmp_ref, dut_rec);
        checked    = pop || bypass;
        match      = checked && (cmp_code == CODE_NONE);
        age_tick   = !empty && enable && !consume && !is_fail && !flush_act;
        timeout    = age_tick && (age == AGE_W'(TIMEOUT - 1));
        fail_evt   = unexpected || timeout || (checked && (cmp_code != CODE_NONE));
        fail_code  = CODE_NONE;
        fail_pc    = dut_pc;
        if (unexpected) begin
            fail_code = CODE_UNEXP;
        end else if (timeout) begin
            fail_code = CODE_TIMEOUT;
            fail_pc   = head.pc;
        end else begin
            fail_code = cmp_code;
        end
        if (flush_act) begin
            occ_next = '0;
        end else begin
            occ_next = occupancy + OCC_W'(store) - OCC_W'(pop);
        end

        case (state)
            S_IDLE: begin
                if (fail_evt) begin
                    state_nxt = S_FAIL;
                end else if (store && !flush_act) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (fail_evt) begin
                    state_nxt = S_FAIL;
                end else if (flush_act || (occ_next == '0)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FAIL: begin
                state_nxt = S_FAIL;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Queue pointers and occupancy; flush rewinds both pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
            if (flush_act) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (store) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Queue storage; contents are only meaningful below occupancy.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= in_rec;
        end
    end

    // Head age: cleared on pop/empty/flush, frozen while enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (flush_act || pop || empty) begin
            age <= '0;
        end else if (age_tick) begin
            age <= age + AGE_W'(1);
        end
    end

    // Sticky first-failure capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error    <= 1'b0;
            err_code <= CODE_NONE;
            err_pc   <= '0;
        end else if (fail_evt) begin
            error    <= 1'b1;
            err_code <= fail_code;
            err_pc   <= fail_pc;
        end
    end

    // Saturating matched-commit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_cnt <= '0;
        end else if (match && (commit_cnt != '1)) begin
            commit_cnt <= commit_cnt + CNT_W'(1);
        end
    end

endmodule
